// File: rtl/pe1_ntt_sched_pkg.sv
// pe1_sched_pkg: shared types, pass counts and per-pass address tables for
// the PE1 NTT sequencer.
//   state_t      sequencer FSM state encoding
//   NPASS_K/D    passes per transform (Kyber / Dilithium)
//   *_TAB        per-pass rotate amount, twiddle shift and twiddle base,
//                indexed by tab_idx({mode_kd, mode_inv, pass[2:0]})
//   rotl6        6-bit rotate-left used for the bank read address
//   radix4       1 when the given pass runs as a Kyber radix-4 pass
package pe1_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int NPASS_K = 4;
   localparam int NPASS_D = 8;

   // Row order: Kyber NTT, Kyber INTT, Dilithium NTT, Dilithium INTT.
   // Kyber rows only use entries 0..3; the rest are padding.
   localparam logic [2:0] ROT_TAB [0:31] = '{
      3'd0, 3'd2, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
      3'd0, 3'd4, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1,
      3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4
   };

   localparam logic [2:0] TW_SH_TAB [0:31] = '{
      3'd5, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
      3'd0, 3'd1, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0,
      3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0,
      3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5
   };

   // Dilithium INTT pass 0 starts at 250 and deliberately wraps the ROM.
   localparam logic [7:0] TW_BASE_TAB [0:31] = '{
      8'd1,   8'd3,   8'd11,  8'd43,  8'd0,   8'd0,   8'd0,   8'd0,
      8'd128, 8'd192, 8'd224, 8'd240, 8'd0,   8'd0,   8'd0,   8'd0,
      8'd1,   8'd2,   8'd4,   8'd8,   8'd16,  8'd32,  8'd96,  8'd160,
      8'd250, 8'd200, 8'd136, 8'd72,  8'd40,  8'd24,  8'd16,  8'd8
   };

   function automatic logic [4:0] tab_idx(logic kd, logic inv, logic [2:0] pass);
      return {kd, inv, pass};
   endfunction

   function automatic logic [5:0] rotl6(logic [5:0] v, logic [2:0] r);
      logic [11:0] d;
      d = {v, v} << r;
      return d[11:6];
   endfunction

   // Kyber NTT runs 4,4,4,2; Kyber INTT runs 2,4,4,4; Dilithium is all radix-2.
   function automatic logic radix4(logic kd, logic inv, logic [3:0] pass);
      if (kd)
         return 1'b0;
      if (inv)
         return pass != 4'd0;
      return pass != 4'd3;
   endfunction

endpackage

// File: rtl/pe1_ntt_sched_if.sv
// pe1_ntt_sched_if: control and bank/ROM address bundle between the
// sequencer (slave) and its requester / PE1 datapath (master).
//   start, mode_kd, mode_inv, stall     requester -> sequencer
//   busy, done                          sequencer status
//   KD_mode, sel_1, sel_0, pass_idx     PE1 pass configuration
//   rd_en, rd_addr, tw_addr             bank read / twiddle ROM address
//   wr_en, wr_addr                      bank write-back
interface pe1_ntt_sched_if #(parameter int TW_AW = 8);
   logic             start;
   logic             mode_kd;
   logic             mode_inv;
   logic             stall;
   logic             busy;
   logic             done;
   logic             KD_mode;
   logic             sel_1;
   logic             sel_0;
   logic             rd_en;
   logic [5:0]       rd_addr;
   logic [TW_AW-1:0] tw_addr;
   logic             wr_en;
   logic [5:0]       wr_addr;
   logic [3:0]       pass_idx;

   modport master (
      output start, mode_kd, mode_inv, stall,
      input  busy, done, KD_mode, sel_1, sel_0, rd_en, rd_addr, tw_addr,
             wr_en, wr_addr, pass_idx
   );

   modport slave (
      input  start, mode_kd, mode_inv, stall,
      output busy, done, KD_mode, sel_1, sel_0, rd_en, rd_addr, tw_addr,
             wr_en, wr_addr, pass_idx
   );
endinterface

// File: rtl/pe1_ntt_sched_dly_line.sv
// sched_dly_line: DEPTH-stage shift register carrying {valid, addr} from
// the read side to the write side. Always shifts; cleared by reset.
//   clk, rst   clock, async active-low reset
//   din        value entering stage 0
//   dout       value leaving the last stage (DEPTH cycles later)
module sched_dly_line #(
   parameter int DEPTH = 6,
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sr [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            sr[i] <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++)
            sr[i] <= sr[i-1];
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pe1_ntt_sched.sv
// pe1_ntt_sched: sequencer for one PE1 butterfly, its coefficient bank and
// twiddle ROM. Runs a 256-point Kyber or Dilithium NTT/INTT as a series of
// passes of N_WORDS bank reads each, followed by a PE_LAT drain.
//   clk, rst   clock, async active-low reset
//   bus        pe1_ntt_sched_if slave: start/mode/stall in, status, PE1
//              configuration, read/twiddle addresses and write-back out
//
// state   | meaning
// S_IDLE  | waiting for start; mode latched on accept
// S_ISSUE | one bank read per non-stalled cycle, N_WORDS per pass
// S_DRAIN | PE_LAT cycles letting the pass's last results write back
// S_DONE  | one-cycle done pulse, then back to idle
module pe1_ntt_sched
   import pe1_sched_pkg::*;
#(
   parameter int PE_LAT  = 6,
   parameter int N_WORDS = 64,
   parameter int TW_AW   = 8
) (
   input  logic                clk,
   input  logic                rst,
   pe1_ntt_sched_if.slave      bus
);

   localparam int DW = $clog2(PE_LAT + 1);

   state_t           state;
   logic [5:0]       cnt;
   logic [3:0]       pass;
   logic [DW-1:0]    drain;
   logic             kd;
   logic             inv;
   logic             sel_0_q;
   logic             busy_q;
   logic             done_q;

   logic [3:0]       npass_m1;
   logic [4:0]       idx;
   logic             rd_en_c;
   logic [5:0]       rot_addr;
   logic [TW_AW-1:0] tw_full;
   logic [6:0]       dly_in;
   logic [6:0]       dly_out;

   assign npass_m1 = kd ? 4'(NPASS_D - 1) : 4'(NPASS_K - 1);
   assign idx      = tab_idx(kd, inv, pass[2:0]);
   assign rd_en_c  = (state == S_ISSUE) && !bus.stall;
   assign rot_addr = rotl6(cnt, ROT_TAB[idx]);
   assign tw_full  = TW_AW'(TW_BASE_TAB[idx]) + TW_AW'(cnt >> TW_SH_TAB[idx]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         pass    <= '0;
         drain   <= '0;
         kd      <= 1'b0;
         inv     <= 1'b0;
         sel_0_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state   <= S_ISSUE;
                  kd      <= bus.mode_kd;
                  inv     <= bus.mode_inv;
                  sel_0_q <= radix4(bus.mode_kd, bus.mode_inv, 4'd0);
                  pass    <= '0;
                  cnt     <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (rd_en_c) begin
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'(N_WORDS - 1)) begin
                     state <= S_DRAIN;
                     drain <= DW'(PE_LAT - 1);
                  end
               end
            end
            S_DRAIN: begin
               if (drain == '0) begin
                  if (pass == npass_m1) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     // Pass configuration only moves here, once the pipe is empty.
                     state   <= S_ISSUE;
                     pass    <= pass + 4'd1;
                     cnt     <= '0;
                     sel_0_q <= radix4(kd, inv, pass + 4'd1);
                  end
               end else begin
                  drain <= drain - DW'(1);
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Addresses are zeroed on idle cycles so stall bubbles carry a clean 0.
   assign dly_in = {rd_en_c, rd_en_c ? rot_addr : 6'd0};

   sched_dly_line #(.DEPTH(PE_LAT), .WIDTH(7)) u_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (dly_in),
      .dout (dly_out)
   );

   assign bus.rd_en    = rd_en_c;
   assign bus.rd_addr  = dly_in[5:0];
   assign bus.tw_addr  = rd_en_c ? tw_full : '0;
   assign bus.wr_en    = dly_out[6];
   assign bus.wr_addr  = dly_out[5:0];
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.KD_mode  = kd;
   assign bus.sel_1    = inv;
   assign bus.sel_0    = sel_0_q;
   assign bus.pass_idx = pass;

endmodule
